// File: rtl/l2_cache_wb.sv
// Set-associative write-back, write-allocate L2 cache with invalid-first / round-robin replacement.
// Define L2_PERF_CNT_EN to add saturating hit, miss and write-back counters.
module l2_cache_wb #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 11,
    parameter int CACHE_SIZE = 512,
    parameter int BLOCK_SIZE = 32,
    parameter int NUM_WAYS   = 4
) (
    input  logic                                                clk,
    input  logic                                                rst_n,
    input  logic [ADDR_WIDTH-1:0]                               l1_cache_addr,
    input  logic [DATA_WIDTH-1:0]                               l1_cache_data_in,
    input  logic                                                l1_cache_read,
    input  logic                                                l1_cache_write,
    output logic [DATA_WIDTH*(BLOCK_SIZE/(DATA_WIDTH/8))-1:0]   l1_block_data_out,
    output logic                                                l1_block_valid,
    output logic                                                l1_cache_ready,
    output logic                                                l1_cache_hit,
    output logic [ADDR_WIDTH-1:0]                               mem_addr,
    output logic [DATA_WIDTH*(BLOCK_SIZE/(DATA_WIDTH/8))-1:0]   mem_data_block_out,
    input  logic [DATA_WIDTH*(BLOCK_SIZE/(DATA_WIDTH/8))-1:0]   mem_data_block,
    output logic                                                mem_read,
    output logic                                                mem_write,
    input  logic                                                mem_ready
`ifdef L2_PERF_CNT_EN
    ,
    output logic [15:0]                                         perf_hits,
    output logic [15:0]                                         perf_misses,
    output logic [15:0]                                         perf_writebacks
`endif
);

    localparam int SETS   = CACHE_SIZE / BLOCK_SIZE / NUM_WAYS;
    localparam int WPB    = BLOCK_SIZE / (DATA_WIDTH / 8);
    localparam int BW     = DATA_WIDTH * WPB;
    localparam int OFF_W  = $clog2(BLOCK_SIZE);
    localparam int IDX_W  = $clog2(SETS);
    localparam int TAG_W  = ADDR_WIDTH - IDX_W - OFF_W;
    localparam int BYTE_W = $clog2(DATA_WIDTH / 8);
    localparam int WSEL_W = (WPB > 1) ? $clog2(WPB) : 1;
    localparam int WAY_W  = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;

    typedef enum logic [1:0] {
        IDLE,
        TAG_CHECK,
        WRITE_BACK,
        ALLOCATE
    } state_t;

    state_t state, state_nxt;

    logic [BW-1:0]       line_mem   [SETS][NUM_WAYS];
    logic [TAG_W-1:0]    tag_mem    [SETS][NUM_WAYS];
    logic [NUM_WAYS-1:0] valid_bits [SETS];
    logic [NUM_WAYS-1:0] dirty_bits [SETS];
    logic [WAY_W-1:0]    rr_ptr     [SETS];

    logic [ADDR_WIDTH-1:0] req_addr, req_addr_nxt;
    logic [DATA_WIDTH-1:0] req_data, req_data_nxt;
    logic                  req_write, req_write_nxt;
    logic [WAY_W-1:0]      victim_way, victim_way_nxt;
    logic                  victim_rr, victim_rr_nxt;

    logic [BW-1:0]         block_out_nxt, mem_block_nxt;
    logic                  block_valid_nxt, ready_nxt, hit_nxt;
    logic [ADDR_WIDTH-1:0] mem_addr_nxt;
    logic                  mem_read_nxt, mem_write_nxt;

    logic [IDX_W-1:0]  req_idx;
    logic [TAG_W-1:0]  req_tag;
    logic [WSEL_W-1:0] word_sel;
    logic              hit_any, inv_any;
    logic [WAY_W-1:0]  hit_way, inv_way, vic_way, rr_next;
    logic [BW-1:0]     hit_line, hit_merged, fill_line, vic_line;
    logic [TAG_W-1:0]  vic_tag;
    logic              vic_dirty;

    function automatic logic [BW-1:0] merge_word(input logic [BW-1:0] line,
                                                 input logic [WSEL_W-1:0] sel,
                                                 input logic [DATA_WIDTH-1:0] word);
        logic [BW-1:0] merged;
        merged = line;
        merged[32'(sel) * DATA_WIDTH +: DATA_WIDTH] = word;
        return merged;
    endfunction

    assign req_idx  = req_addr[OFF_W +: IDX_W];
    assign req_tag  = req_addr[ADDR_WIDTH-1 -: TAG_W];
    assign word_sel = (WPB > 1) ? WSEL_W'(req_addr >> BYTE_W) : '0;

    always_comb begin
        logic [WAY_W-1:0] wi;
        hit_any = 1'b0;
        hit_way = '0;
        inv_any = 1'b0;
        inv_way = '0;
        wi      = '0;
        for (int unsigned w = 0; w < NUM_WAYS; w++) begin
            wi = WAY_W'(w);
            if (!hit_any && valid_bits[req_idx][wi] && tag_mem[req_idx][wi] == req_tag) begin
                hit_any = 1'b1;
                hit_way = wi;
            end
            if (!inv_any && !valid_bits[req_idx][wi]) begin
                inv_any = 1'b1;
                inv_way = wi;
            end
        end
    end

    assign vic_way    = inv_any ? inv_way : rr_ptr[req_idx];
    assign vic_line   = line_mem[req_idx][vic_way];
    assign vic_tag    = tag_mem[req_idx][vic_way];
    assign vic_dirty  = valid_bits[req_idx][vic_way] & dirty_bits[req_idx][vic_way];
    assign hit_line   = line_mem[req_idx][hit_way];
    assign hit_merged = merge_word(hit_line, word_sel, req_data);
    assign fill_line  = req_write ? merge_word(mem_data_block, word_sel, req_data) : mem_data_block;
    assign rr_next    = (rr_ptr[req_idx] == WAY_W'(NUM_WAYS - 1)) ? '0 : rr_ptr[req_idx] + 1'b1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state              <= IDLE;
            req_addr           <= '0;
            req_data           <= '0;
            req_write          <= 1'b0;
            victim_way         <= '0;
            victim_rr          <= 1'b0;
            l1_block_data_out  <= '0;
            l1_block_valid     <= 1'b0;
            l1_cache_ready     <= 1'b0;
            l1_cache_hit       <= 1'b0;
            mem_addr           <= '0;
            mem_data_block_out <= '0;
            mem_read           <= 1'b0;
            mem_write          <= 1'b0;
        end else begin
            state              <= state_nxt;
            req_addr           <= req_addr_nxt;
            req_data           <= req_data_nxt;
            req_write          <= req_write_nxt;
            victim_way         <= victim_way_nxt;
            victim_rr          <= victim_rr_nxt;
            l1_block_data_out  <= block_out_nxt;
            l1_block_valid     <= block_valid_nxt;
            l1_cache_ready     <= ready_nxt;
            l1_cache_hit       <= hit_nxt;
            mem_addr           <= mem_addr_nxt;
            mem_data_block_out <= mem_block_nxt;
            mem_read           <= mem_read_nxt;
            mem_write          <= mem_write_nxt;
        end
    end

    // Outputs are registered: this block computes the value each output takes after the edge.
    always_comb begin
        state_nxt       = state;
        req_addr_nxt    = req_addr;
        req_data_nxt    = req_data;
        req_write_nxt   = req_write;
        victim_way_nxt  = victim_way;
        victim_rr_nxt   = victim_rr;
        block_out_nxt   = l1_block_data_out;
        block_valid_nxt = 1'b0;
        ready_nxt       = 1'b0;
        hit_nxt         = 1'b0;
        mem_addr_nxt    = mem_addr;
        mem_block_nxt   = mem_data_block_out;
        mem_read_nxt    = mem_read;
        mem_write_nxt   = mem_write;
        case (state)
            IDLE: begin
                if ((l1_cache_read || l1_cache_write) && !l1_cache_ready) begin
                    req_addr_nxt  = l1_cache_addr;
                    req_data_nxt  = l1_cache_data_in;
                    req_write_nxt = l1_cache_write;
                    state_nxt     = TAG_CHECK;
                end
            end
            TAG_CHECK: begin
                if (hit_any) begin
                    block_out_nxt   = req_write ? hit_merged : hit_line;
                    block_valid_nxt = 1'b1;
                    hit_nxt         = 1'b1;
                    ready_nxt       = 1'b1;
                    state_nxt       = IDLE;
                end else begin
                    victim_way_nxt = vic_way;
                    victim_rr_nxt  = !inv_any;
                    if (vic_dirty) begin
                        mem_addr_nxt  = {vic_tag, req_idx, {OFF_W{1'b0}}};
                        mem_block_nxt = vic_line;
                        mem_write_nxt = 1'b1;
                        state_nxt     = WRITE_BACK;
                    end else begin
                        mem_addr_nxt = {req_tag, req_idx, {OFF_W{1'b0}}};
                        mem_read_nxt = 1'b1;
                        state_nxt    = ALLOCATE;
                    end
                end
            end
            WRITE_BACK: begin
                if (mem_ready) begin
                    mem_write_nxt = 1'b0;
                    mem_read_nxt  = 1'b1;
                    mem_addr_nxt  = {req_tag, req_idx, {OFF_W{1'b0}}};
                    state_nxt     = ALLOCATE;
                end
            end
            ALLOCATE: begin
                if (mem_ready) begin
                    mem_read_nxt    = 1'b0;
                    block_out_nxt   = fill_line;
                    block_valid_nxt = 1'b1;
                    ready_nxt       = 1'b1;
                    state_nxt       = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned s = 0; s < SETS; s++) begin
                valid_bits[s] <= '0;
                dirty_bits[s] <= '0;
                rr_ptr[s]     <= '0;
            end
        end else begin
            case (state)
                TAG_CHECK: begin
                    if (hit_any && req_write) dirty_bits[req_idx][hit_way] <= 1'b1;
                end
                WRITE_BACK: begin
                    if (mem_ready) dirty_bits[req_idx][victim_way] <= 1'b0;
                end
                ALLOCATE: begin
                    if (mem_ready) begin
                        valid_bits[req_idx][victim_way] <= 1'b1;
                        dirty_bits[req_idx][victim_way] <= req_write;
                        if (victim_rr) rr_ptr[req_idx] <= rr_next;
                    end
                end
                default: ;
            endcase
        end
    end

    // Line and tag storage carry no reset; the valid bits alone decide whether they count.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (state == TAG_CHECK && hit_any && req_write)
                line_mem[req_idx][hit_way] <= hit_merged;
            if (state == ALLOCATE && mem_ready) begin
                line_mem[req_idx][victim_way] <= fill_line;
                tag_mem[req_idx][victim_way]  <= req_tag;
            end
        end
    end

`ifdef L2_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_hits       <= '0;
            perf_misses     <= '0;
            perf_writebacks <= '0;
        end else begin
            if (state == TAG_CHECK) begin
                if (hit_any) begin
                    if (perf_hits != '1) perf_hits <= perf_hits + 16'd1;
                end else if (perf_misses != '1) begin
                    perf_misses <= perf_misses + 16'd1;
                end
            end
            if (state == WRITE_BACK && mem_ready && perf_writebacks != '1)
                perf_writebacks <= perf_writebacks + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_l2_cache_wb.sv
// Scoreboard bench for l2_cache_wb: expected lines come from a flat architectural memory image,
// and a memory responder checks every write-back against that image.
module tb_l2_cache_wb;

    logic         clk;
    logic         rst_n;
    logic [10:0]  l1_cache_addr;
    logic [31:0]  l1_cache_data_in;
    logic         l1_cache_read;
    logic         l1_cache_write;
    logic [255:0] l1_block_data_out;
    logic         l1_block_valid;
    logic         l1_cache_ready;
    logic         l1_cache_hit;
    logic [10:0]  mem_addr;
    logic [255:0] mem_data_block_out;
    logic [255:0] mem_data_block;
    logic         mem_read;
    logic         mem_write;
    logic         mem_ready;
`ifdef L2_PERF_CNT_EN
    logic [15:0]  perf_hits, perf_misses, perf_writebacks;
`endif

    l2_cache_wb #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(11),
        .CACHE_SIZE(512),
        .BLOCK_SIZE(32),
        .NUM_WAYS(4)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .l1_cache_addr(l1_cache_addr),
        .l1_cache_data_in(l1_cache_data_in),
        .l1_cache_read(l1_cache_read),
        .l1_cache_write(l1_cache_write),
        .l1_block_data_out(l1_block_data_out),
        .l1_block_valid(l1_block_valid),
        .l1_cache_ready(l1_cache_ready),
        .l1_cache_hit(l1_cache_hit),
        .mem_addr(mem_addr),
        .mem_data_block_out(mem_data_block_out),
        .mem_data_block(mem_data_block),
        .mem_read(mem_read),
        .mem_write(mem_write),
        .mem_ready(mem_ready)
`ifdef L2_PERF_CNT_EN
        ,
        .perf_hits(perf_hits),
        .perf_misses(perf_misses),
        .perf_writebacks(perf_writebacks)
`endif
    );

    typedef struct {
        logic [255:0] line;
        logic         hit;
    } exp_t;

    exp_t         exp_q[$];
    logic [255:0] back_mem [64];
    logic [255:0] golden   [64];
    int           n_total = 0;
    int           n_bad = 0;
    int           resp_cnt = 0;
    int           rd_cnt = 0;
    int           wb_cnt = 0;
    int           mem_delay = 2;
    logic [10:0]  last_rd_addr = '0;
    logic [10:0]  last_wb_addr = '0;
    logic         all_done = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] want);
        n_total++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s got=%h want=%h", tag, got, want);
        end
    endtask

    // Memory responder: waits mem_delay cycles with the request held, then pulses mem_ready.
    initial begin
        logic         op_wr;
        logic [10:0]  a;
        logic [255:0] d;
        logic         aborted;
        mem_ready = 1'b0;
        mem_data_block = '0;
        forever begin
            @(negedge clk);
            if (rst_n && (mem_read || mem_write)) begin
                op_wr = mem_write;
                a = mem_addr;
                d = mem_data_block_out;
                aborted = 1'b0;
                for (int i = 0; i < mem_delay && !aborted; i++) begin
                    @(negedge clk);
                    if (!rst_n) aborted = 1'b1;
                    else check("mem_hold", {mem_write, mem_read, mem_addr, mem_data_block_out},
                               {op_wr, !op_wr, a, op_wr ? d : mem_data_block_out});
                end
                if (!aborted) begin
                    if (op_wr) begin
                        wb_cnt++;
                        last_wb_addr = a;
                        check("wb_data", d, golden[a[10:5]]);
                        back_mem[a[10:5]] = d;
                    end else begin
                        rd_cnt++;
                        last_rd_addr = a;
                        mem_data_block = back_mem[a[10:5]];
                    end
                    mem_ready = 1'b1;
                    @(negedge clk);
                    mem_ready = 1'b0;
                end
            end
        end
    end

    // Response monitor: pops the scoreboard on every ready pulse.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (mem_read || mem_write) check("mem_excl", mem_read & mem_write, 1'b0);
            if (l1_cache_ready) begin
                resp_cnt++;
                check("blk_valid", l1_block_valid, 1'b1);
                check("resp_pending", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("line", l1_block_data_out, e.line);
                    check("hit", l1_cache_hit, e.hit);
                end
            end
        end
    end

    task automatic do_req(input logic [10:0] addr, input logic [31:0] data, input logic rd,
                          input logic wr, input logic exp_hit, input logic exp_wb,
                          input logic [10:0] exp_wb_addr, input logic exp_rd,
                          input logic [10:0] exp_rd_addr);
        exp_t         e;
        logic [255:0] ln;
        logic [5:0]   blk;
        int           w, rc0, wc0, sr, lat;
        logic         done;
        blk = addr[10:5];
        w = int'(addr[4:2]);
        ln = golden[blk];
        if (wr) begin
            ln[w*32 +: 32] = data;
            golden[blk] = ln;
        end
        e.line = ln;
        e.hit = exp_hit;
        exp_q.push_back(e);
        rc0 = rd_cnt;
        wc0 = wb_cnt;
        sr = resp_cnt;
        @(negedge clk);
        l1_cache_addr = addr;
        l1_cache_data_in = data;
        l1_cache_read = rd;
        l1_cache_write = wr;
        @(negedge clk);
        l1_cache_read = 1'b0;
        l1_cache_write = 1'b0;
        lat = 1;
        done = 1'b0;
        for (int i = 0; i < 300 && !done; i++) begin
            #1;
            if (resp_cnt != sr) done = 1'b1;
            else begin
                @(negedge clk);
                lat++;
            end
        end
        check("resp_timeout", done, 1'b1);
        if (exp_hit) check("hit_latency", lat, 2);
        check("rd_count", rd_cnt - rc0, exp_rd);
        check("wb_count", wb_cnt - wc0, exp_wb);
        if (exp_rd) check("rd_addr", last_rd_addr, exp_rd_addr);
        if (exp_wb) check("wb_addr", last_wb_addr, exp_wb_addr);
    endtask

    initial begin
        logic  seen;
`ifdef L2_PERF_CNT_EN
        logic [15:0] m0, w0;
`endif
        for (int b = 0; b < 64; b++) begin
            for (int i = 0; i < 8; i++)
                back_mem[b][i*32 +: 32] = (b == 2) ? (32'h0000_00A0 + i) : (32'hC000_0000 | (b << 16) | i);
            golden[b] = back_mem[b];
        end
        rst_n = 1'b0;
        l1_cache_addr = '0;
        l1_cache_data_in = '0;
        l1_cache_read = 1'b0;
        l1_cache_write = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_block", l1_block_data_out, '0);
        check("rst_mem_block", mem_data_block_out, '0);
        check("rst_ctrl", {l1_block_valid, l1_cache_ready, l1_cache_hit, mem_read, mem_write, mem_addr}, '0);
        rst_n = 1'b1;

        // cold read, then hits on the same line
        do_req(11'h040, 32'h0, 1, 0, 0, 0, 11'h0, 1, 11'h040);
        do_req(11'h044, 32'h0, 1, 0, 1, 0, 11'h0, 0, 11'h0);
        do_req(11'h048, 32'hDEADBEEF, 0, 1, 1, 0, 11'h0, 0, 11'h0);
        check("word2", l1_block_data_out[95:64], 32'hDEADBEEF);

        // fill set 0, dirty way 0, evict it
        do_req(11'h000, 32'h0, 1, 0, 0, 0, 11'h0, 1, 11'h000);
        do_req(11'h080, 32'h0, 1, 0, 0, 0, 11'h0, 1, 11'h080);
        do_req(11'h100, 32'h0, 1, 0, 0, 0, 11'h0, 1, 11'h100);
        do_req(11'h180, 32'h0, 1, 0, 0, 0, 11'h0, 1, 11'h180);
        do_req(11'h004, 32'h11111111, 0, 1, 1, 0, 11'h0, 0, 11'h0);
`ifdef L2_PERF_CNT_EN
        m0 = perf_misses;
        w0 = perf_writebacks;
`endif
        do_req(11'h200, 32'h0, 1, 0, 0, 1, 11'h000, 1, 11'h200);
`ifdef L2_PERF_CNT_EN
        check("perf_miss", perf_misses - m0, 16'd1);
        check("perf_wb", perf_writebacks - w0, 16'd1);
`endif
        // round-robin now at way 1; clean victim with slow memory
        mem_delay = 10;
        do_req(11'h280, 32'h0, 1, 0, 0, 0, 11'h0, 1, 11'h280);
        mem_delay = 2;
        do_req(11'h000, 32'h0, 1, 0, 0, 0, 11'h0, 1, 11'h000);
        do_req(11'h080, 32'h0, 1, 0, 0, 0, 11'h0, 1, 11'h080);
        do_req(11'h100, 32'h0, 1, 0, 0, 0, 11'h0, 1, 11'h100);
        do_req(11'h280, 32'h0, 1, 0, 1, 0, 11'h0, 0, 11'h0);
        do_req(11'h000, 32'h0, 1, 0, 1, 0, 11'h0, 0, 11'h0);

        // read and write together behave as a write
        do_req(11'h044, 32'h55AA55AA, 1, 1, 1, 0, 11'h0, 0, 11'h0);

        // reset in the middle of a write-back
        do_req(11'h0C0, 32'h0, 1, 0, 0, 0, 11'h0, 1, 11'h0C0);
        do_req(11'h140, 32'h0, 1, 0, 0, 0, 11'h0, 1, 11'h140);
        do_req(11'h1C0, 32'h0, 1, 0, 0, 0, 11'h0, 1, 11'h1C0);
        mem_delay = 20;
        @(negedge clk);
        l1_cache_addr = 11'h240;
        l1_cache_read = 1'b1;
        @(negedge clk);
        l1_cache_read = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = mem_write;
        end
        check("wb_start", seen, 1'b1);
        check("wb_start_addr", mem_addr, 11'h040);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_wb_block", l1_block_data_out, '0);
        check("rst_wb_mem_block", mem_data_block_out, '0);
        check("rst_wb_ctrl", {l1_block_valid, l1_cache_ready, l1_cache_hit, mem_read, mem_write, mem_addr}, '0);
        rst_n = 1'b1;
        exp_q.delete();
        for (int b = 0; b < 64; b++) golden[b] = back_mem[b];
        mem_delay = 2;
        do_req(11'h040, 32'h0, 1, 0, 0, 0, 11'h0, 1, 11'h040);

        // write miss allocates dirty; its eviction writes the merged line back
        do_req(11'h2A8, 32'h12345678, 0, 1, 0, 0, 11'h0, 1, 11'h2A0);
        do_req(11'h2A0, 32'h0, 1, 0, 1, 0, 11'h0, 0, 11'h0);
        do_req(11'h020, 32'h0, 1, 0, 0, 0, 11'h0, 1, 11'h020);
        do_req(11'h0A0, 32'h0, 1, 0, 0, 0, 11'h0, 1, 11'h0A0);
        do_req(11'h120, 32'h0, 1, 0, 0, 0, 11'h0, 1, 11'h120);
        do_req(11'h1A0, 32'h0, 1, 0, 0, 1, 11'h2A0, 1, 11'h1A0);

        repeat (3) @(negedge clk);
        check("scoreboard_empty", exp_q.size(), 0);
        all_done = 1'b1;
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #500000;
        check("watchdog", all_done, 1'b1);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
